// File: rtl/muldiv_pkg.sv
// muldiv_pkg: RV32M funct3 codes, multiply/divide FSM state encoding and
// the operation-class helper shared by the ex_muldiv slice.
package muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_t;

  // DIV/DIVU/REM/REMU all have funct3[2] set.
  function automatic logic is_div(input logic [2:0] funct3);
    return funct3[2];
  endfunction

endpackage

// File: rtl/md_div_core.sv
// md_div_core: one restoring-division step on unsigned magnitudes.
// Shifts the next dividend bit (quo MSB) into the partial remainder and
// subtracts the divisor when it fits, shifting the quotient bit into quo.
module md_div_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_nxt,
  output logic [XLEN-1:0] quo_nxt
);

  logic [XLEN:0] shifted;

  // Trial subtract; the difference always fits XLEN bits since shifted < 2*divisor.
  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    if (shifted >= {1'b0, divisor}) begin
      rem_nxt = shifted[XLEN-1:0] - divisor;
      quo_nxt = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_nxt = shifted[XLEN-1:0];
      quo_nxt = {quo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit for the EX stage.
// Works on operand magnitudes in unsigned 2*XLEN registers and applies the
// sign at the end. Optional macro MULDIV_FAST_MUL_EN makes MUL* single-cycle.
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            cpurst,
  input  logic            md_valid,
  input  logic [2:0]      md_funct3,
  input  logic [XLEN-1:0] md_op1,
  input  logic [XLEN-1:0] md_op2,
  input  logic            ex_hold,
  input  logic            flush,
  output logic            mult_stall,
  output logic [XLEN-1:0] md_result,
  output logic            md_result_valid,
  output logic            md_busy
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t          state;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         f_r;
  logic               neg_q, neg_r;
  logic [2*XLEN-1:0]  acc, acc_nxt, b_reg, b_nxt;
  logic [XLEN-1:0]    a_reg, a_nxt;
  logic               op1_signed, op2_signed, s1, s2;
  logic [XLEN-1:0]    mag1, mag2;
  logic               direct;
  logic [XLEN-1:0]    direct_val;
  logic [XLEN-1:0]    rem_step, quo_step;
  logic [XLEN-1:0]    final_res;

  // Sign-correct and select the architectural result from a magnitude result.
  // Multiply/quotient negate on differing signs; remainder follows the dividend.
  function automatic logic [XLEN-1:0] fin(input logic [2:0] f, input logic [2*XLEN-1:0] w,
                                          input logic nq, input logic nr);
    logic [2*XLEN-1:0] p;
    logic [XLEN-1:0]   q, r, res;
    p = nq ? -w : w;
    q = nq ? -w[XLEN-1:0] : w[XLEN-1:0];
    r = nr ? -w[2*XLEN-1:XLEN] : w[2*XLEN-1:XLEN];
    case (f)
      MD_MUL:                        res = p[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  res = p[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:               res = q;
      default:                       res = r;
    endcase
    return res;
  endfunction

  // Operand decode: signedness, magnitudes and ops that finish without iterating.
  always_comb begin
    op1_signed = (md_funct3 == MD_MULH) || (md_funct3 == MD_MULHSU) ||
                 (md_funct3 == MD_DIV)  || (md_funct3 == MD_REM);
    op2_signed = (md_funct3 == MD_MULH) || (md_funct3 == MD_DIV) || (md_funct3 == MD_REM);
    s1   = op1_signed & md_op1[XLEN-1];
    s2   = op2_signed & md_op2[XLEN-1];
    mag1 = s1 ? -md_op1 : md_op1;
    mag2 = s2 ? -md_op2 : md_op2;
    direct     = 1'b0;
    direct_val = '0;
    if (is_div(md_funct3)) begin
      if (md_op2 == '0) begin
        direct     = 1'b1;
        direct_val = ((md_funct3 == MD_DIV) || (md_funct3 == MD_DIVU)) ? '1 : md_op1;
      end else if (((md_funct3 == MD_DIV) || (md_funct3 == MD_REM)) &&
                   (md_op1 == MOST_NEG) && (md_op2 == '1)) begin
        direct     = 1'b1;
        direct_val = (md_funct3 == MD_DIV) ? MOST_NEG : '0;
      end
    end
`ifdef MULDIV_FAST_MUL_EN
    else begin
      direct     = 1'b1;
      direct_val = fin(md_funct3, {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2}, s1 ^ s2, s1);
    end
`endif
  end

  md_div_core #(.XLEN(XLEN)) u_div (
    .rem     (acc[2*XLEN-1:XLEN]),
    .quo     (acc[XLEN-1:0]),
    .divisor (b_reg[XLEN-1:0]),
    .rem_nxt (rem_step),
    .quo_nxt (quo_step)
  );

  // One radix-2 step: restoring divide on {rem,quo}, or shift-add multiply into acc.
  always_comb begin
    if (is_div(f_r)) begin
      acc_nxt = {rem_step, quo_step};
      b_nxt   = b_reg;
      a_nxt   = a_reg;
    end else begin
      acc_nxt = acc + (a_reg[0] ? b_reg : '0);
      b_nxt   = b_reg << 1;
      a_nxt   = a_reg >> 1;
    end
    final_res = fin(f_r, acc_nxt, neg_q, neg_r);
  end

  // Control FSM with datapath registers; flush wins over any new md_valid.
  always_ff @(posedge clk) begin
    if (cpurst) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      md_result       <= '0;
      md_result_valid <= 1'b0;
      f_r             <= MD_MUL;
      neg_q           <= 1'b0;
      neg_r           <= 1'b0;
      acc             <= '0;
      b_reg           <= '0;
      a_reg           <= '0;
    end else if (flush) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      md_result_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (md_valid) begin
            f_r   <= md_funct3;
            neg_q <= s1 ^ s2;
            neg_r <= s1;
            cnt   <= '0;
            acc   <= is_div(md_funct3) ? {{XLEN{1'b0}}, mag1} : '0;
            b_reg <= is_div(md_funct3) ? {{XLEN{1'b0}}, mag2} : {{XLEN{1'b0}}, mag1};
            a_reg <= mag2;
            if (direct) begin
              md_result       <= direct_val;
              md_result_valid <= 1'b1;
              state           <= ST_DONE;
            end else begin
              state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          acc   <= acc_nxt;
          b_reg <= b_nxt;
          a_reg <= a_nxt;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_STEP) begin
            md_result       <= final_res;
            md_result_valid <= 1'b1;
            state           <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!ex_hold) begin
            md_result_valid <= 1'b0;
            state           <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mult_stall = !cpurst && !flush &&
                      (((state == ST_IDLE) && md_valid) || (state == ST_BUSY));
  assign md_busy    = !cpurst && (state != ST_IDLE);

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed and randomized checks of ex_muldiv against an
// arithmetic reference model (honours MULDIV_FAST_MUL_EN for MUL latency).
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        cpurst, md_valid, ex_hold, flush;
  logic [2:0]  md_funct3;
  logic [31:0] md_op1, md_op2;
  logic        mult_stall, md_result_valid, md_busy;
  logic [31:0] md_result;

  int n_vec = 0;
  int n_err = 0;

  ex_muldiv #(.XLEN(32), .CNT_W(6)) dut (
    .clk             (clk),
    .cpurst          (cpurst),
    .md_valid        (md_valid),
    .md_funct3       (md_funct3),
    .md_op1          (md_op1),
    .md_op2          (md_op2),
    .ex_hold         (ex_hold),
    .flush           (flush),
    .mult_stall      (mult_stall),
    .md_result       (md_result),
    .md_result_valid (md_result_valid),
    .md_busy         (md_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result from plain 64-bit integer arithmetic.
  function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'(b);
    p  = '0;
    r  = '0;
    case (f)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : 32'(sa % sb);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f >= 3'd4) begin
      if (b == 0) return 2;
      if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
      return 34;
    end
`ifdef MULDIV_FAST_MUL_EN
    return 2;
`else
    return 34;
`endif
  endfunction

  // Issue one op from IDLE and follow it to DONE; leaves the op sitting in DONE.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int n, stalls, lat;
    logic [31:0] exp;
    exp = ref_md(f, a, b);
    lat = ref_lat(f, a, b);
    md_funct3 = f; md_op1 = a; md_op2 = b; md_valid = 1'b1;
    #1;
    check({tag, " stall_c1"}, 64'(mult_stall), 64'd1);
    n = 1; stalls = 1;
    do begin
      @(posedge clk); #1;
      n++;
      if (md_result_valid !== 1'b1 && mult_stall === 1'b1) stalls++;
    end while (md_result_valid !== 1'b1 && n < 200);
    check({tag, " latency"}, 64'(n), 64'(lat));
    check({tag, " stall_cycles"}, 64'(stalls), 64'(lat - 1));
    check({tag, " stall_done"}, 64'(mult_stall), 64'd0);
    check({tag, " result"}, 64'(md_result), 64'(exp));
  endtask

  task automatic finish_op(input string tag);
    md_valid = 1'b0;
    @(posedge clk); #1;
    check({tag, " idle_busy"}, 64'(md_busy), 64'd0);
    check({tag, " idle_valid"}, 64'(md_result_valid), 64'd0);
  endtask

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra, rb, held;
    cpurst = 1'b1; md_valid = 1'b0; md_funct3 = '0; md_op1 = '0; md_op2 = '0;
    ex_hold = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst result", 64'(md_result), 64'd0);
    check("rst valid", 64'(md_result_valid), 64'd0);
    check("rst stall", 64'(mult_stall), 64'd0);
    check("rst busy", 64'(md_busy), 64'd0);
    cpurst = 1'b0;
    @(posedge clk); #1;

    run_op("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD);          finish_op("MUL 7*-3");
    run_op("MULHU ff*ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF); finish_op("MULHU");
    run_op("MULH ff*ff", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  finish_op("MULH");
    run_op("MULHSU -2*big", 3'd2, 32'hFFFF_FFFE, 32'hF000_0001); finish_op("MULHSU");
    run_op("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2);           finish_op("DIV -7/2");
    run_op("REM -7%2", 3'd6, 32'hFFFF_FFF9, 32'd2);           finish_op("REM -7%2");
    run_op("DIVU 100/7", 3'd5, 32'd100, 32'd7);               finish_op("DIVU 100/7");
    run_op("DIV 5/0", 3'd4, 32'd5, 32'd0);                    finish_op("DIV 5/0");
    run_op("REMU 5%0", 3'd7, 32'd5, 32'd0);                   finish_op("REMU 5%0");
    run_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);    finish_op("DIV ovf");
    run_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);    finish_op("REM ovf");

    // Flush during BUSY cycle 10.
    md_funct3 = 3'd5; md_op1 = 32'd1000; md_op2 = 32'd3; md_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("flush busy_before", 64'(md_busy), 64'd1);
    flush = 1'b1; md_valid = 1'b0;
    #1;
    check("flush stall_same", 64'(mult_stall), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy_after", 64'(md_busy), 64'd0);
    check("flush valid_after", 64'(md_result_valid), 64'd0);
    check("flush stall_after", 64'(mult_stall), 64'd0);
    run_op("DIVU 9/3", 3'd5, 32'd9, 32'd3);                   finish_op("DIVU 9/3");

    // New md_valid coinciding with flush is dropped.
    md_funct3 = 3'd5; md_op1 = 32'd9; md_op2 = 32'd3; md_valid = 1'b1; flush = 1'b1;
    #1;
    check("flushvalid stall", 64'(mult_stall), 64'd0);
    @(posedge clk); #1;
    check("flushvalid busy", 64'(md_busy), 64'd0);
    flush = 1'b0; md_valid = 1'b0;
    @(posedge clk); #1;

    // ex_hold keeps the result in DONE without restarting.
    run_op("hold DIVU", 3'd5, 32'd100, 32'd7);
    held = ref_md(3'd5, 32'd100, 32'd7);
    ex_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold valid", 64'(md_result_valid), 64'd1);
      check("hold result", 64'(md_result), 64'(held));
      check("hold busy", 64'(md_busy), 64'd1);
      check("hold stall", 64'(mult_stall), 64'd0);
    end
    ex_hold = 1'b0;
    finish_op("hold release");

    // Reset mid-BUSY with md_valid still asserted.
    md_funct3 = 3'd0; md_op1 = 32'd123; md_op2 = 32'd456; md_valid = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    cpurst = 1'b1;
    @(posedge clk); #1;
    check("midrst stall", 64'(mult_stall), 64'd0);
    check("midrst busy", 64'(md_busy), 64'd0);
    check("midrst valid", 64'(md_result_valid), 64'd0);
    check("midrst result", 64'(md_result), 64'd0);
    cpurst = 1'b0; md_valid = 1'b0;
    @(posedge clk); #1;

    // Randomized ops with boundary operands mixed in.
    for (int k = 0; k < 40; k++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = 32'($urandom_range(0, 50)); rb = 32'($urandom_range(1, 9)); end
        3: rb = -32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op($sformatf("rand%0d f%0d", k, rf), rf, ra, rb);
      finish_op("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
